// File: rtl/fusion_input_aligner_if.sv
// Two serial sensor element streams in, parallel operand vectors out toward Fusion_unit.
interface fusion_input_aligner_if #(
  parameter int DW = 16,
  parameter int N  = 6
);
  logic                 s1_valid;
  logic                 s1_ready;
  logic [2:0]           s1_idx;
  logic signed [DW-1:0] s1_x;
  logic signed [DW-1:0] s1_p;
  logic                 s1_last;

  logic                 s2_valid;
  logic                 s2_ready;
  logic [2:0]           s2_idx;
  logic signed [DW-1:0] s2_x;
  logic signed [DW-1:0] s2_p;
  logic                 s2_last;

  logic                 out_valid;
  logic                 out_ready;
  logic [N*DW-1:0]      x1_vec;
  logic [N*DW-1:0]      p1_vec;
  logic [N*DW-1:0]      x2_vec;
  logic [N*DW-1:0]      p2_vec;
  logic                 frame_err;
  logic                 timeout_err;

  modport slave (
    input  s1_valid, s1_idx, s1_x, s1_p, s1_last,
    input  s2_valid, s2_idx, s2_x, s2_p, s2_last,
    input  out_ready,
    output s1_ready, s2_ready,
    output out_valid, x1_vec, p1_vec, x2_vec, p2_vec,
    output frame_err, timeout_err
  );

  modport master (
    output s1_valid, s1_idx, s1_x, s1_p, s1_last,
    output s2_valid, s2_idx, s2_x, s2_p, s2_last,
    output out_ready,
    input  s1_ready, s2_ready,
    input  out_valid, x1_vec, p1_vec, x2_vec, p2_vec,
    input  frame_err, timeout_err
  );
endinterface

// File: rtl/fusion_input_aligner.sv
// Gathers one N-element (X,P) frame per sensor and releases both together as
// parallel vectors; malformed or stale frames are dropped with an error pulse.
module fusion_input_aligner #(
  parameter int DW      = 16,
  parameter int N       = 6,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input logic                   clk,
  input logic                   rst,
  fusion_input_aligner_if.slave bus
);

  typedef enum logic {S_COLLECT = 1'b0, S_FULL = 1'b1} sns_state_t;
  typedef enum logic [1:0] {P_IDLE = 2'd0, P_WAIT = 2'd1, P_OUT = 2'd2} pair_state_t;

  localparam logic [2:0]    LAST_SLOT = 3'(N - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  logic                 in_vld  [2];
  logic [2:0]           in_idx  [2];
  logic signed [DW-1:0] in_x    [2];
  logic signed [DW-1:0] in_p    [2];
  logic                 in_last [2];

  assign in_vld[0]  = bus.s1_valid;
  assign in_idx[0]  = bus.s1_idx;
  assign in_x[0]    = bus.s1_x;
  assign in_p[0]    = bus.s1_p;
  assign in_last[0] = bus.s1_last;
  assign in_vld[1]  = bus.s2_valid;
  assign in_idx[1]  = bus.s2_idx;
  assign in_x[1]    = bus.s2_x;
  assign in_p[1]    = bus.s2_p;
  assign in_last[1] = bus.s2_last;

  sns_state_t    sns_q [2];
  sns_state_t    sns_d [2];
  logic [2:0]    cnt_q [2];
  logic [2:0]    cnt_d [2];
  pair_state_t   pair_q, pair_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ferr_q, ferr_d;
  logic          terr_q, terr_d;

  logic rdy  [2];
  logic acc  [2];
  logic bad  [2];
  logic wr   [2];
  logic done [2];
  logic tmo_fire;
  logic out_fire;

  logic signed [DW-1:0] xb_q [2][N];
  logic signed [DW-1:0] pb_q [2][N];

  // Beat classification: a beat must land in the expected slot, carry last
  // exactly on the final slot, and have a strictly positive covariance.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      rdy[s]  = (sns_q[s] == S_COLLECT);
      acc[s]  = in_vld[s] && rdy[s];
      bad[s]  = acc[s] && ((in_idx[s] != cnt_q[s]) ||
                           (in_last[s] != (cnt_q[s] == LAST_SLOT)) ||
                           in_p[s][DW-1] || (in_p[s] == '0));
      wr[s]   = acc[s] && !bad[s];
      done[s] = wr[s] && (cnt_q[s] == LAST_SLOT);
    end
  end

  always_comb begin
    pair_d   = pair_q;
    tmr_d    = tmr_q;
    tmo_fire = 1'b0;
    out_fire = 1'b0;
    unique case (pair_q)
      P_IDLE: begin
        if (done[0] && done[1]) begin
          pair_d = P_OUT;
        end else if (done[0] || done[1]) begin
          pair_d = P_WAIT;
          tmr_d  = '0;
        end
      end
      P_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        // The missing frame arriving on the deadline cycle still counts.
        if (done[0] || done[1]) begin
          pair_d = P_OUT;
        end else if (tmr_q == TMO_LAST) begin
          tmo_fire = 1'b1;
          pair_d   = P_IDLE;
        end
      end
      P_OUT: begin
        if (bus.out_ready) begin
          out_fire = 1'b1;
          pair_d   = P_IDLE;
        end
      end
      default: pair_d = P_IDLE;
    endcase
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      sns_d[s] = sns_q[s];
      cnt_d[s] = cnt_q[s];
      if (bad[s]) begin
        cnt_d[s] = '0;
      end else if (done[s]) begin
        sns_d[s] = S_FULL;
        cnt_d[s] = '0;
      end else if (wr[s]) begin
        cnt_d[s] = cnt_q[s] + 3'd1;
      end
      // Only the sensor that was already full is released on a timeout;
      // the other keeps its partial frame.
      if (out_fire || (tmo_fire && (sns_q[s] == S_FULL))) begin
        sns_d[s] = S_COLLECT;
        cnt_d[s] = '0;
      end
    end
    ferr_d = bad[0] || bad[1];
    terr_d = tmo_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        sns_q[s] <= S_COLLECT;
        cnt_q[s] <= '0;
      end
      pair_q <= P_IDLE;
      tmr_q  <= '0;
      ferr_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        sns_q[s] <= sns_d[s];
        cnt_q[s] <= cnt_d[s];
      end
      pair_q <= pair_d;
      tmr_q  <= tmr_d;
      ferr_q <= ferr_d;
      terr_q <= terr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < N; k++) begin
          xb_q[s][k] <= '0;
          pb_q[s][k] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wr[s]) begin
          xb_q[s][cnt_q[s]] <= in_x[s];
          pb_q[s][cnt_q[s]] <= in_p[s];
        end
      end
    end
  end

  // Readies are forced low while reset is held, independent of the flops.
  assign bus.s1_ready    = rdy[0] && !rst;
  assign bus.s2_ready    = rdy[1] && !rst;
  assign bus.out_valid   = (pair_q == P_OUT);
  assign bus.frame_err   = ferr_q;
  assign bus.timeout_err = terr_q;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign bus.x1_vec[DW*k +: DW] = xb_q[0][k];
    assign bus.p1_vec[DW*k +: DW] = pb_q[0][k];
    assign bus.x2_vec[DW*k +: DW] = xb_q[1][k];
    assign bus.p2_vec[DW*k +: DW] = pb_q[1][k];
  end

endmodule

// File: tb/tb_fusion_input_aligner.sv
// Bench for fusion_input_aligner: directed scenarios plus randomized frames,
// with expected vectors taken from the frames the bench itself sends.
module tb_fusion_input_aligner;
  localparam int DW  = 16;
  localparam int N   = 6;
  localparam int TMO = 8;
  localparam int TW  = 4;

  logic clk = 1'b0;
  logic rst;

  fusion_input_aligner_if #(.DW(DW), .N(N)) bus ();

  fusion_input_aligner #(.DW(DW), .N(N), .TIMEOUT(TMO), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int ferr_seen = 0;
  int ferr_exp  = 0;
  int terr_seen = 0;
  int full_cyc  = 0;

  logic [N*DW-1:0] fr_x [2];
  logic [N*DW-1:0] fr_p [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_err)   ferr_seen++;
    if (bus.timeout_err) terr_seen++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference rule for a malformed beat arriving when pos elements are stored.
  function automatic bit bad_beat(input int pos, input int idx, input int p, input bit last);
    return (idx != pos) || (last != (pos == N - 1)) || (p <= 0);
  endfunction

  function automatic bit rdy(input int s);
    return (s == 0) ? bus.s1_ready : bus.s2_ready;
  endfunction

  task automatic drive(input int s, input bit v, input int idx,
                       input logic [DW-1:0] x, input logic [DW-1:0] p, input bit last);
    if (s == 0) begin
      bus.s1_valid = v; bus.s1_idx = 3'(idx); bus.s1_x = x; bus.s1_p = p; bus.s1_last = last;
    end else begin
      bus.s2_valid = v; bus.s2_idx = 3'(idx); bus.s2_x = x; bus.s2_p = p; bus.s2_last = last;
    end
  endtask

  task automatic beat(input int s, input int idx, input logic [DW-1:0] x,
                      input logic [DW-1:0] p, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    drive(s, 1'b1, idx, x, p, last);
    while (!rdy(s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(s)) begin
      chk("beat_ready_wait", 0, 1);
      drive(s, 1'b0, 0, '0, '0, 1'b0);
    end else begin
      @(posedge clk);
      #1;
      drive(s, 1'b0, 0, '0, '0, 1'b0);
    end
  endtask

  task automatic send_range(input int s, input int lo, input int hi);
    for (int k = lo; k <= hi; k++)
      beat(s, k, fr_x[s][DW*k +: DW], fr_p[s][DW*k +: DW], k == N - 1);
  endtask

  task automatic send_pair(input int mode);
    if (mode == 0) begin
      for (int k = 0; k < N; k++) begin
        beat(0, k, fr_x[0][DW*k +: DW], fr_p[0][DW*k +: DW], k == N - 1);
        beat(1, k, fr_x[1][DW*k +: DW], fr_p[1][DW*k +: DW], k == N - 1);
      end
    end else if (mode == 1) begin
      send_range(0, 0, N - 1);
      send_range(1, 0, N - 1);
    end else begin
      send_range(1, 0, N - 1);
      send_range(0, 0, N - 1);
    end
  endtask

  task automatic rand_frame(input int s);
    for (int k = 0; k < N; k++) begin
      fr_x[s][DW*k +: DW] = DW'($urandom);
      case ($urandom_range(0, 7))
        0:       fr_p[s][DW*k +: DW] = DW'(1);
        1:       fr_p[s][DW*k +: DW] = DW'(32767);
        default: fr_p[s][DW*k +: DW] = DW'($urandom_range(1, 32767));
      endcase
    end
  endtask

  task automatic set_sc1();
    for (int k = 0; k < N; k++) begin
      fr_x[0][DW*k +: DW] = DW'(100 + 10 * k);
      fr_p[0][DW*k +: DW] = DW'(20 + 10 * k);
      fr_x[1][DW*k +: DW] = DW'(80 + 10 * k);
      fr_p[1][DW*k +: DW] = DW'(10 + 5 * k);
    end
  endtask

  // Called right after the completing beat; checks latency, hold, data, release.
  task automatic check_out(input string tag, input int hold);
    chk({tag, "_latency"}, bus.out_valid, 1'b1);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold"}, {bus.out_valid, bus.s1_ready, bus.s2_ready}, 3'b100);
      chk({tag, "_stable"}, bus.x2_vec, fr_x[1]);
    end
    @(negedge clk);
    chk({tag, "_x1"}, bus.x1_vec, fr_x[0]);
    chk({tag, "_p1"}, bus.p1_vec, fr_p[0]);
    chk({tag, "_x2"}, bus.x2_vec, fr_x[1]);
    chk({tag, "_p2"}, bus.p2_vec, fr_p[1]);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_release"}, {bus.out_valid, bus.s1_ready, bus.s2_ready}, 3'b011);
  endtask

  initial begin
    bit seen;
    int s, k, t, bi, bp;
    bit bl, e;

    drive(0, 1'b0, 0, '0, '0, 1'b0);
    drive(1, 1'b0, 0, '0, '0, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", {bus.s1_ready, bus.s2_ready}, 2'b00);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_vectors", bus.x1_vec | bus.p1_vec | bus.x2_vec | bus.p2_vec, 0);
    chk("reset_err", {bus.frame_err, bus.timeout_err}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_ready", {bus.s1_ready, bus.s2_ready}, 2'b11);

    // Scenario 1: interleaved known frames, immediate consume.
    set_sc1();
    send_pair(0);
    chk("sc1_x1_elem0", bus.x1_vec[15:0], 128'd100);
    chk("sc1_p2_elem5", bus.p2_vec[95:80], 128'd35);
    check_out("sc1", 0);

    // Scenario 2: consumer stalls for 10 cycles.
    set_sc1();
    send_pair(0);
    check_out("sc2", 10);

    // Scenario 3: s1 full, s2 partial then silent -> timeout; then recovery.
    rand_frame(0);
    rand_frame(1);
    send_range(0, 0, N - 1);
    full_cyc = cyc;
    send_range(1, 0, 2);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.timeout_err) seen = 1'b1;
    end
    chk("sc3_timeout_seen", seen, 1'b1);
    chk("sc3_timeout_latency", cyc - full_cyc, TMO);
    chk("sc3_ready_after", {bus.out_valid, bus.s1_ready, bus.s2_ready}, 3'b011);
    rand_frame(0);
    send_range(0, 0, N - 1);
    send_range(1, 3, N - 1);
    check_out("sc3", 2);

    // Scenario 4: s2 skips idx 2 -> frame error, then restarts cleanly.
    rand_frame(0);
    rand_frame(1);
    send_range(1, 0, 1);
    e = bad_beat(2, 3, int'($signed(fr_p[1][DW*3 +: DW])), 1'b0);
    ferr_exp += int'(e);
    beat(1, 3, fr_x[1][DW*3 +: DW], fr_p[1][DW*3 +: DW], 1'b0);
    chk("sc4_frame_err", bus.frame_err, e);
    send_pair(0);
    check_out("sc4", 1);

    // Scenario 5: non-positive covariance on element 2, twice.
    rand_frame(0);
    send_range(0, 0, 1);
    e = bad_beat(2, 2, 0, 1'b0);
    ferr_exp += int'(e);
    beat(0, 2, fr_x[0][DW*2 +: DW], DW'(0), 1'b0);
    chk("sc5_p_zero_err", bus.frame_err, e);
    send_range(0, 0, 1);
    e = bad_beat(2, 2, -5, 1'b0);
    ferr_exp += int'(e);
    beat(0, 2, fr_x[0][DW*2 +: DW], DW'(-5), 1'b0);
    chk("sc5_p_neg_err", bus.frame_err, e);
    @(negedge clk);
    chk("sc5_no_output", {bus.out_valid, bus.s1_ready}, 2'b01);

    // Scenario 6: reset in the middle of collection.
    rand_frame(0);
    rand_frame(1);
    for (int j = 0; j < 4; j++) begin
      beat(0, j, fr_x[0][DW*j +: DW], fr_p[0][DW*j +: DW], 1'b0);
      beat(1, j, fr_x[1][DW*j +: DW], fr_p[1][DW*j +: DW], 1'b0);
    end
    send_range(1, 4, N - 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sc6_rst_out", {bus.out_valid, bus.s1_ready, bus.s2_ready}, 3'b000);
    chk("sc6_rst_vectors", bus.x1_vec | bus.p1_vec | bus.x2_vec | bus.p2_vec, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_sc1();
    send_pair(1);
    chk("sc6_x1_elem0", bus.x1_vec[15:0], 128'd100);
    check_out("sc6", 0);

    // Randomized frames, orderings, stalls and injected malformed beats.
    for (int it = 0; it < 16; it++) begin
      rand_frame(0);
      rand_frame(1);
      if ($urandom_range(0, 2) != 0) begin
        s  = $urandom_range(0, 1);
        k  = $urandom_range(0, N - 2);
        t  = $urandom_range(0, 2);
        bi = k;
        bp = $urandom_range(1, 32767);
        bl = 1'b0;
        send_range(s, 0, k - 1);
        case (t)
          0:       bi = k + 1;
          1:       bp = 0 - int'($urandom_range(0, 32768));
          default: bl = 1'b1;
        endcase
        e = bad_beat(k, bi, bp, bl);
        ferr_exp += int'(e);
        beat(s, bi, DW'($urandom), DW'(bp), bl);
        chk("rnd_frame_err", bus.frame_err, e);
      end
      send_pair($urandom_range(0, 2));
      check_out("rnd", $urandom_range(0, 4));
    end

    repeat (2) @(negedge clk);
    chk("total_frame_err", ferr_seen, ferr_exp);
    chk("total_timeout_err", terr_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
